// File: rtl/mezcladora_param.sv
// mezcladora_param: parametrised batch-mixer controller.
//
// Runs one batch as IDLE -> FILL(0..N_ING-1) -> MIX -> DRAIN -> IDLE.
// Each fill phase and the drain phase has a watchdog. If a phase stays too
// long, the controller moves to FAULT and holds there until ACK.
// Completed batches are counted, and the count wraps.
//
// Ports
//   Clk       rising-edge clock
//   Reset     synchronous, active-low reset
//   IN        start request (only looked at in IDLE)
//   TOK       one-cycle timer tick (only counted in MIX)
//   LVL[k]    level reached for ingredient k (only looked at in FILL(k))
//   EMPTY     tank empty (only looked at in DRAIN)
//   ACK       fault acknowledge (only looked at in FAULT)
//   V[k]      ingredient valve k open
//   M, T      mixer motor on, mix timer running
//   S         drain valve open
//   B         alarm, fault latched
//   BUSY      neither IDLE nor FAULT
//   BATCH     completed-batch count, wraps modulo 2^BATCH_W
//   dbg_state registered FSM state, for observation only
//
// All outputs are a Moore decode of registered state. Because of that, a
// transition sampled at an edge shows on the outputs at that same edge.
module mezcladora_param #(
  parameter int N_ING       = 3,
  parameter int MIX_TICKS   = 4,
  parameter int TIMEOUT_CYC = 64,
  parameter int BATCH_W     = 8
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               IN,
  input  logic               TOK,
  input  logic [N_ING-1:0]   LVL,
  input  logic               EMPTY,
  input  logic               ACK,
  output logic [N_ING-1:0]   V,
  output logic               M,
  output logic               T,
  output logic               S,
  output logic               B,
  output logic               BUSY,
  output logic [BATCH_W-1:0] BATCH,
  output logic [2:0]         dbg_state
);

  localparam int TW = (MIX_TICKS > 1)   ? $clog2(MIX_TICKS)   : 1;
  localparam int WW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int IW = (N_ING > 1)       ? $clog2(N_ING)       : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(MIX_TICKS - 1);
  localparam logic [WW-1:0] WD_LAST   = WW'(TIMEOUT_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N_ING - 1);

  // FILL is one encoded state. The ingredient index is held in fill_idx.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_MIX   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  state_t             state, state_n;
  logic [IW-1:0]      fill_idx, fill_idx_n;
  logic [TW-1:0]      tick_cnt, tick_cnt_n;
  logic [WW-1:0]      wd_cnt, wd_cnt_n;
  logic [BATCH_W-1:0] batch_q, batch_n;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      fill_idx <= '0;
      tick_cnt <= '0;
      wd_cnt   <= '0;
      batch_q  <= '0;
    end else begin
      state    <= state_n;
      fill_idx <= fill_idx_n;
      tick_cnt <= tick_cnt_n;
      wd_cnt   <= wd_cnt_n;
      batch_q  <= batch_n;
    end
  end

  // Each watchdog counter leaves its phase on the cycle it reaches
  // TIMEOUT_CYC-1, so it never wraps. The tick counter does the same at
  // MIX_TICKS-1. An exit condition is tested before the timeout, so it wins
  // when both are true on the same cycle.
  always_comb begin
    state_n    = state;
    fill_idx_n = fill_idx;
    tick_cnt_n = tick_cnt;
    wd_cnt_n   = wd_cnt;
    batch_n    = batch_q;
    case (state)
      ST_IDLE: begin
        if (IN) begin
          state_n    = ST_FILL;
          fill_idx_n = '0;
          wd_cnt_n   = '0;
        end
      end
      ST_FILL: begin
        if (LVL[fill_idx]) begin
          wd_cnt_n = '0;
          if (fill_idx == IDX_LAST) begin
            state_n    = ST_MIX;
            tick_cnt_n = '0;
          end else begin
            fill_idx_n = fill_idx + 1'b1;
          end
        end else if (wd_cnt == WD_LAST) begin
          state_n  = ST_FAULT;
          wd_cnt_n = '0;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end
      ST_MIX: begin
        if (TOK) begin
          if (tick_cnt == TICK_LAST) begin
            state_n    = ST_DRAIN;
            tick_cnt_n = '0;
            wd_cnt_n   = '0;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (EMPTY) begin
          state_n  = ST_IDLE;
          wd_cnt_n = '0;
          batch_n  = batch_q + 1'b1;
        end else if (wd_cnt == WD_LAST) begin
          state_n  = ST_FAULT;
          wd_cnt_n = '0;
        end else begin
          wd_cnt_n = wd_cnt + 1'b1;
        end
      end
      ST_FAULT: begin
        if (ACK) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // Moore output decode
  always_comb begin
    V = '0;
    if (state == ST_FILL) begin
      V = N_ING'(1) << fill_idx;
    end
  end

  assign M         = (state == ST_MIX);
  assign T         = (state == ST_MIX);
  assign S         = (state == ST_DRAIN);
  assign B         = (state == ST_FAULT);
  assign BUSY      = (state != ST_IDLE) && (state != ST_FAULT);
  assign BATCH     = batch_q;
  assign dbg_state = state;

endmodule
